// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store stage over an 8-bit arbitrated memory port; MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] store_data_i,
  output logic [6:0]  opcode_o,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_dout_o,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_din_i,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign_o,
`endif
  output logic        stallreq_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n, last, pidx;
  logic pend, is_ld, is_st, vld, mis, act, fin;
  logic [3:0][7:0] rbuf;
  logic [31:0] ld_val;
  assign is_ld = opcode_i == 7'b0000011;
  assign is_st = opcode_i == 7'b0100011;
  assign vld = (is_ld & (funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) | (is_st & (funct3_i <= 3'd2));
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = (funct3_i[1:0] == 2'd1 & alu_i[0]) | (funct3_i[1:0] == 2'd2 & |alu_i[1:0]);
  assign misalign_o = rst & vld & mis;
`else
  assign mis = 1'b0;
`endif
  assign act = vld & ~mis;
  assign last = funct3_i[1:0] == 2'd0 ? 2'd0 : funct3_i[1:0] == 2'd1 ? 2'd1 : 2'd3;
  assign fin = cnt == last;
  assign opcode_o = opcode_i;
  assign waddr_o = waddr_i;
  assign we_o = we_i & (~(is_ld | is_st) | act);
  assign mem_req_o = rst & act & (state == IDLE || state == ISSUE);
  assign mem_wr_o = mem_req_o & is_st;
  assign mem_addr_o = alu_i + {30'd0, cnt};
  assign mem_dout_o = store_data_i[{cnt, 3'b000} +: 8];
  assign stallreq_o = rst & act & (state != DONE);
  // loads narrower than a word extend from the top byte actually fetched
  assign ld_val = funct3_i[1:0] == 2'd0 ? {{24{~funct3_i[2] & rbuf[0][7]}}, rbuf[0]} :
                  funct3_i[1:0] == 2'd1 ? {{16{~funct3_i[2] & rbuf[1][7]}}, rbuf[1], rbuf[0]} : rbuf;
  assign wdata_o = !(is_ld | is_st) ? alu_i : (act && is_ld && state == DONE) ? ld_val : 32'd0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (!act || state == DONE) begin
      state_n = IDLE;
      cnt_n = 2'd0;
    end else if (state == DRAIN) begin
      state_n = DONE;
    end else if (mem_grant_i) begin
      cnt_n = fin ? 2'd0 : cnt + 2'd1;
      state_n = !fin ? ISSUE : is_ld ? DRAIN : DONE;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      pend <= 1'b0;
      pidx <= 2'd0;
      rbuf <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pend <= mem_req_o & ~mem_wr_o & mem_grant_i;
      pidx <= cnt;
      if (pend) rbuf[pidx] <= mem_din_i;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors and multi-cycle load/store sequences against a byte RAM model
module tb_mem_stage;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, NOP = 7'b0010011, ADD = 7'b0110011;
  logic clk, rst, we_i, we_o, mem_req_o, mem_wr_o, mem_grant_i, stallreq_o;
  logic [6:0] opcode_i, opcode_o;
  logic [2:0] funct3_i;
  logic [4:0] waddr_i, waddr_o;
  logic [31:0] alu_i, store_data_i, wdata_o, mem_addr_o;
  logic [7:0] mem_dout_o, mem_din_i;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_o;
`endif
  logic [7:0] ram [0:1023];
  logic [31:0] rlog[$], reqlog[$];
  logic [39:0] wlog[$];
  int tests = 0, fails = 0, cyc, st;
  logic [31:0] wd;
  typedef struct {
    string nm;
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] alu;
    logic ewe;
    logic [31:0] ewd;
    logic estall;
    logic ereq;
  } vec_t;
  vec_t vt[10];

  mem_stage dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .funct3_i(funct3_i), .we_i(we_i), .waddr_i(waddr_i),
    .alu_i(alu_i), .store_data_i(store_data_i), .opcode_o(opcode_o), .we_o(we_o), .waddr_o(waddr_o),
    .wdata_o(wdata_o), .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_dout_o(mem_dout_o), .mem_grant_i(mem_grant_i), .mem_din_i(mem_din_i),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o(misalign_o),
`endif
    .stallreq_o(stallreq_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst && mem_req_o && mem_grant_i) begin
      if (mem_wr_o) begin
        ram[mem_addr_o[9:0]] = mem_dout_o;
        wlog.push_back({mem_addr_o, mem_dout_o});
      end else begin
        mem_din_i <= ram[mem_addr_o[9:0]];
        rlog.push_back(mem_addr_o);
      end
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [15:0] gp,
                        output int c_o, output int s_o, output logic [31:0] w_o);
    bit done = 0;
    c_o = 0;
    s_o = 0;
    w_o = 'x;
    opcode_i = op; funct3_i = f3; alu_i = addr; store_data_i = sd; we_i = 1;
    rlog.delete(); wlog.delete(); reqlog.delete();
    for (int c = 0; c < 16 && !done; c++) begin
      mem_grant_i = gp[c];
      #1;
      c_o++;
      if (mem_req_o) reqlog.push_back(mem_addr_o);
      if (stallreq_o) s_o++;
      else begin
        done = 1;
        w_o = wdata_o;
      end
      @(posedge clk); #1;
    end
    chk("op_completes", {31'd0, done}, 32'd1);
    opcode_i = NOP; alu_i = 0; mem_grant_i = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h84;
    ram[10'h104] = 8'h55; ram[10'h105] = 8'h66; ram[10'h203] = 8'h80;
    ram[10'h030] = 8'h00; ram[10'h031] = 8'h9A; ram[10'h3FF] = 8'h01; ram[10'h000] = 8'h80;
    vt[0] = '{"add",   ADD,          3'd0, 32'h12345678, 1'b1, 32'h12345678, 1'b0, 1'b0};
    vt[1] = '{"lui",   7'b0110111,   3'd0, 32'hFFFFF000, 1'b1, 32'hFFFFF000, 1'b0, 1'b0};
    vt[2] = '{"branch",7'b1100011,   3'd1, 32'h00000001, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vt[3] = '{"ld_f3", LOAD,         3'd3, 32'h00000100, 1'b0, 32'h0,        1'b0, 1'b0};
    vt[4] = '{"ld_f6", LOAD,         3'd6, 32'h00000100, 1'b0, 32'h0,        1'b0, 1'b0};
    vt[5] = '{"ld_f7", LOAD,         3'd7, 32'h00000100, 1'b0, 32'h0,        1'b0, 1'b0};
    vt[6] = '{"st_f3", STORE,        3'd3, 32'h00000100, 1'b0, 32'h0,        1'b0, 1'b0};
    vt[7] = '{"st_f7", STORE,        3'd7, 32'h00000100, 1'b0, 32'h0,        1'b0, 1'b0};
    vt[8] = '{"lw_wait", LOAD,       3'd2, 32'h00000100, 1'b1, 32'h0,        1'b1, 1'b1};
    vt[9] = '{"sb_wait", STORE,      3'd0, 32'h00000040, 1'b1, 32'h0,        1'b1, 1'b1};
    rst = 0; opcode_i = LOAD; funct3_i = 3'd2; we_i = 1; waddr_i = 5'd7;
    alu_i = 32'h100; store_data_i = 0; mem_grant_i = 1;
    #12;
    chk("rst_req", {31'd0, mem_req_o}, 0);
    chk("rst_wr", {31'd0, mem_wr_o}, 0);
    chk("rst_stall", {31'd0, stallreq_o}, 0);
    @(posedge clk); #1;
    rst = 1; opcode_i = NOP; alu_i = 0; mem_grant_i = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      opcode_i = vt[i].op; funct3_i = vt[i].f3; alu_i = vt[i].alu; we_i = 1; waddr_i = 5'd7;
      #2;
      chk({vt[i].nm, "_ctl"}, {20'd0, opcode_o, waddr_o}, {20'd0, vt[i].op, 5'd7});
      chk({vt[i].nm, "_we"}, {31'd0, we_o}, {31'd0, vt[i].ewe});
      chk({vt[i].nm, "_wdata"}, wdata_o, vt[i].ewd);
      chk({vt[i].nm, "_stall_req"}, {30'd0, stallreq_o, mem_req_o}, {30'd0, vt[i].estall, vt[i].ereq});
      @(posedge clk); #1;
    end
    opcode_i = NOP; alu_i = 0;
    @(posedge clk); #1;
    run_op(LOAD, 3'd2, 32'h100, 0, 16'hFFFF, cyc, st, wd);
    chk("lw_cycles", cyc, 6); chk("lw_stall", st, 5); chk("lw_data", wd, 32'h84332211);
    chk("lw_reads", rlog.size(), 4); chk("lw_last_addr", rlog[3], 32'h103);
    run_op(LOAD, 3'd0, 32'h203, 0, 16'hFFFF, cyc, st, wd);
    chk("lb_cycles", cyc, 3); chk("lb_stall", st, 2); chk("lb_data", wd, 32'hFFFFFF80);
    run_op(LOAD, 3'd4, 32'h203, 0, 16'hFFFF, cyc, st, wd);
    chk("lbu_cycles", cyc, 3); chk("lbu_data", wd, 32'h00000080);
    run_op(LOAD, 3'd1, 32'h30, 0, 16'hFFFF, cyc, st, wd);
    chk("lh_cycles", cyc, 4); chk("lh_data", wd, 32'hFFFF9A00);
    run_op(LOAD, 3'd5, 32'h30, 0, 16'hFFFF, cyc, st, wd);
    chk("lhu_data", wd, 32'h00009A00);
    run_op(STORE, 3'd1, 32'h10, 32'hDEADBEEF, 16'hFFFD, cyc, st, wd);
    chk("sh_cycles", cyc, 4); chk("sh_stall", st, 3); chk("sh_wdata", wd, 0);
    chk("sh_reqs", reqlog.size(), 3); chk("sh_repeat_addr", reqlog[2], 32'h11);
    chk("sh_writes", wlog.size(), 2);
    chk("sh_byte0", {24'd0, ram[10'h010]}, 32'hEF); chk("sh_byte1", {24'd0, ram[10'h011]}, 32'hBE);
    run_op(STORE, 3'd2, 32'h20, 32'h12345678, 16'hFFFF, cyc, st, wd);
    chk("sw_cycles", cyc, 5); chk("sw_stall", st, 4);
    chk("sw_mem", {ram[10'h023], ram[10'h022], ram[10'h021], ram[10'h020]}, 32'h12345678);
    run_op(STORE, 3'd0, 32'h40, 32'hAABBCCDD, 16'hFFFF, cyc, st, wd);
    chk("sb_cycles", cyc, 2); chk("sb_stall", st, 1);
    chk("sb_mem", {16'd0, ram[10'h041], ram[10'h040]}, 32'h000000DD);
    // reset lands while the third byte of a word load is on the bus
    rlog.delete();
    opcode_i = LOAD; funct3_i = 3'd2; alu_i = 32'h100; mem_grant_i = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_req", {31'd0, mem_req_o}, 1); chk("mid_addr", mem_addr_o, 32'h102);
    rst = 0; #1;
    chk("mid_rst_req", {31'd0, mem_req_o}, 0); chk("mid_rst_stall", {31'd0, stallreq_o}, 0);
    @(posedge clk); #1;
    opcode_i = ADD; funct3_i = 3'd0; alu_i = 32'hCAFEF00D; rst = 1; #1;
    chk("post_rst_add", wdata_o, 32'hCAFEF00D); chk("post_rst_stall", {31'd0, stallreq_o}, 0);
    @(posedge clk); #1;
    chk("post_rst_req", {31'd0, mem_req_o}, 0); chk("post_rst_reads", rlog.size(), 2);
    opcode_i = NOP; alu_i = 0; mem_grant_i = 0;
    @(posedge clk); #1;
`ifdef MEM_MISALIGN_TRAP_EN
    rlog.delete();
    opcode_i = LOAD; funct3_i = 3'd2; alu_i = 32'h102; we_i = 1; mem_grant_i = 1; #1;
    chk("mis_flag", {31'd0, misalign_o}, 1); chk("mis_req", {31'd0, mem_req_o}, 0);
    chk("mis_stall", {31'd0, stallreq_o}, 0); chk("mis_we", {31'd0, we_o}, 0);
    @(posedge clk); #1;
    opcode_i = STORE; funct3_i = 3'd1; alu_i = 32'h11; #1;
    chk("mis_sh_flag", {31'd0, misalign_o}, 1); chk("mis_sh_wr", {31'd0, mem_wr_o}, 0);
    @(posedge clk); #1;
    opcode_i = NOP; alu_i = 0; mem_grant_i = 0; #1;
    chk("mis_pulse_end", {31'd0, misalign_o}, 0); chk("mis_no_access", rlog.size() + wlog.size(), 0);
`else
    run_op(LOAD, 3'd2, 32'h102, 0, 16'hFFFF, cyc, st, wd);
    chk("unal_cycles", cyc, 6); chk("unal_data", wd, 32'h66558433);
    chk("unal_first", rlog[0], 32'h102); chk("unal_last", rlog[3], 32'h105);
    run_op(LOAD, 3'd1, 32'hFFFFFFFF, 0, 16'hFFFF, cyc, st, wd);
    chk("wrap_addr", rlog[1], 32'h0); chk("wrap_data", wd, 32'hFFFF8001);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
